// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with a small prefetch FIFO.
// Owns the fetch PC (driven out as imem_addr) and captures the returned word.
// Presents the head entry {instr, instr_pc} over a valid/ready handshake.
// A redirect flushes the queue and restarts fetch at the target.
// Ports:
//   clk, reset (sync, active-low)
//   imem_addr / imem_data     : instruction memory (combinational read)
//   redirect / redirect_pc    : flush-and-restart request and target
//   out_valid / out_ready     : consumer handshake; instr / instr_pc = head entry
//   count                     : number of occupied entries
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned CW       = 2
) (
  input  logic          clk,
  input  logic          reset,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_data,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   instr,
  output logic [31:0]   instr_pc,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   ins_q [DEPTH];
  logic [31:0]   ins_d [DEPTH];
  logic [31:0]   epc_q [DEPTH];
  logic [31:0]   epc_d [DEPTH];
  logic          push, pop;

  // Low address bits of the redirect target are ignored (word aligned).
  logic unused_rpc_lsbs;
  assign unused_rpc_lsbs = ^redirect_pc[1:0];

  // Head outputs are combinational from the queue; zero while empty.
  assign out_valid = (count_q != '0);
  assign instr     = out_valid ? ins_q[rd_ptr_q] : 32'h0;
  assign instr_pc  = out_valid ? epc_q[rd_ptr_q] : 32'h0;
  assign count     = count_q;
  assign imem_addr = fetch_pc_q;

  // Next-state: flush on redirect, otherwise push/pop with a full-with-pop bypass.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ins_d      = ins_q;
    epc_d      = epc_q;
    pop        = out_valid & out_ready;
    push       = ~redirect & ((count_q < CW'(DEPTH)) | pop);

    if (redirect) begin
      // Simultaneous pop is swallowed by the flush.
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else begin
      if (push) begin
        ins_d[wr_ptr_q] = imem_data;
        epc_d[wr_ptr_q] = fetch_pc_q;
        wr_ptr_d        = wr_ptr_q + 1'b1;
        fetch_pc_d      = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State register; reset dominates redirect, push and pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ins_q[i] <= 32'h0;
        epc_q[i] <= 32'h0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ins_q      <= ins_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the execution datapath.
- Owns the fetch PC and drives the instruction-memory address.
- Captures the returned instruction word into a small prefetch FIFO and presents {instr, instr_pc} to the consumer over a valid/ready handshake.
- A redirect from downstream (branch, jump or jr resolved in execution) flushes the queue and restarts fetch at the target.

Parameters:
- RESET_PC, 32'h0000_0000: fetch PC loaded on reset.
- DEPTH, 2: queue entries; power of two, minimum 2.
- CW, 2: count width, equal to log2(DEPTH)+1.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-low; sampled on the rising edge of clk; 0 = reset.
- imem_addr, output, 32: byte address to instruction memory; always equals fetch_pc.
- imem_data, input, 32: instruction word at imem_addr; combinational read, valid in the same cycle.
- redirect, input, 1: flush-and-restart request.
- redirect_pc, input, 32: restart target; bits [1:0] forced to 0.
- out_valid, output, 1: queue head holds a valid entry.
- out_ready, input, 1: consumer accepts the head this cycle.
- instr, output, 32: head instruction word.
- instr_pc, output, 32: byte address of the head instruction.
- count, output, CW: number of occupied entries.

Behaviour:
- Reset (reset==0 at an edge):
  - fetch_pc <= RESET_PC; queue emptied; count=0; out_valid=0.
  - instr and instr_pc read 0 while the queue is empty.
  - Reset takes priority over redirect, push and pop.
- Outputs:
  - instr, instr_pc and out_valid are driven combinationally from the head entry.
  - out_valid = (count != 0).
- Handshake:
  - pop = out_valid & out_ready.
  - The consumer may assert out_ready at any time; out_ready while empty has no effect.
  - The head entry is held stable until popped.
- Push:
  - push = ~redirect & (count < DEPTH | pop).
  - On push, the entry {imem_data, fetch_pc} is written at the tail and fetch_pc <= fetch_pc + 4.
- Full: when count==DEPTH and no pop occurs, there is no push and fetch_pc holds.
- Full with pop: push and pop in the same cycle leaves count unchanged and is a legal steady-state throughput of 1 instruction per cycle.
- Latency:
  - The first instruction (at RESET_PC) becomes valid in the cycle after reset deasserts.
  - A fetch-to-output latency of 1 cycle applies to every push.
- Redirect (reset==1, redirect==1 at an edge):
  - All entries are discarded and count <= 0, including any simultaneous pop.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; no push that cycle.
  - out_valid is 0 in the following cycle, and the target instruction becomes valid one cycle after that.
- Wrap-around:
  - fetch_pc is 32-bit modulo, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
  - Queue read and write pointers wrap modulo DEPTH.
- Count arithmetic: count' = count + push - pop; it never exceeds DEPTH and never goes below 0.
- Memory access: imem_addr changes only on an edge, so no combinational path exists from out_ready or redirect to imem_addr.

Test Plan:
- Reset then free-run: memory preloaded at 0x0,0x4,0x8 with 0x20080005, 0x20090006, 0x01095020; reset low for 1 edge; out_ready=1.
  - out_valid rises 1 cycle after release.
  - Output stream is (0x0,0x20080005), (0x4,0x20090006), (0x8,0x01095020) on consecutive cycles.
- Backpressure: out_ready=0 for 5 cycles after reset.
  - count goes 1,2 then holds at 2; imem_addr holds at 0x8.
  - The head stays (0x0,0x20080005) until out_ready=1, then the stream continues in order with no loss or duplication.
- Full plus simultaneous pop: with count=2, assert out_ready=1.
  - Each cycle has one pop and one push, count stays 2, and fetch_pc advances by 4 per cycle.
- Redirect flush: with count=2 and head at 0x4, pulse redirect with redirect_pc=0x43 and out_ready=1.
  - Next cycle: count=0, out_valid=0, imem_addr=0x40.
  - Following cycle: head is (0x40, mem[0x40]).
- Reset mid-operation: with count=2 and fetch_pc=0x10, drive reset=0 together with redirect=1 and redirect_pc=0x80.
  - Next cycle: count=0 and imem_addr=RESET_PC (0x0), not 0x80.
- Address wrap: redirect_pc=0xFFFFFFFC.
  - Entries appear in order (0xFFFFFFFC, ...) then (0x00000000, mem[0x0]).
